// File: rtl/multi_event_counter_pkg.sv
// Shared opcodes, edge-mode encodings, status layout and channel control bundle
// for the multi-channel event counter.
package multi_event_counter_pkg;

  // Custom-instruction opcodes carried in ciValueA[3:0]
  localparam logic [3:0] OP_READ_COUNT   = 4'd0;
  localparam logic [3:0] OP_CLEAR_COUNT  = 4'd1;
  localparam logic [3:0] OP_CLEAR_ALL    = 4'd2;
  localparam logic [3:0] OP_SNAPSHOT     = 4'd3;
  localparam logic [3:0] OP_READ_SHADOW  = 4'd4;
  localparam logic [3:0] OP_WRITE_CFG    = 4'd5;
  localparam logic [3:0] OP_WRITE_THRESH = 4'd6;
  localparam logic [3:0] OP_READ_STATUS  = 4'd7;
  localparam logic [3:0] OP_CLEAR_FLAGS  = 4'd8;

  // Bit offsets of the flag groups inside the status word
  localparam int STATUS_OVF_LSB = 0;
  localparam int STATUS_THR_LSB = 16;

  // Which input transitions a channel counts
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Per-channel control strobes decoded from the CI bus, valid for one cycle
  typedef struct packed {
    logic clear;
    logic snapshot;
    logic cfg_we;
    logic thresh_we;
    logic ovf_clr;
    logic thr_clr;
  } chan_ctrl_t;

  // True when the cur/prev sample pair is a transition the mode asks for
  function automatic logic edge_hit(input edge_mode_t mode, input logic cur, input logic prev);
    return (mode[0] & cur & ~prev) | (mode[1] & ~cur & prev);
  endfunction

endpackage

// File: rtl/multi_event_counter_channel.sv
// One event-counter channel: optional synchroniser, primed edge detector,
// wrap/saturate counter, sticky overflow and threshold flags, snapshot shadow.
module event_counter_channel
  import multi_event_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     event_in,
  input  chan_ctrl_t               ctrl,
  input  logic [31:0]              wdata,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic [COUNTER_WIDTH-1:0] shadow,
  output logic                     ovf_flag,
  output logic                     thr_flag
);

  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;
  // The detector stays disarmed until a level present at reset release has
  // walked through the synchroniser and the sample/prev pair, so it is never
  // mistaken for an edge.
  localparam int PRIME_CYCLES = SYNC_STAGES + 2;

  logic synced;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign synced = event_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      // Shift the raw event line through the synchroniser flops
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_reg <= '0;
        end else begin
          sync_reg[0] <= event_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_reg[i] <= sync_reg[i-1];
          end
        end
      end
      assign synced = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic                     sample_reg;
  logic                     prev_reg;
  logic [2:0]               prime_reg;
  logic                     armed;
  logic                     hit;
  edge_mode_t               mode_reg;
  logic                     sat_reg;
  logic [COUNTER_WIDTH-1:0] thresh_reg;
  logic [COUNTER_WIDTH-1:0] count_reg;
  logic [COUNTER_WIDTH-1:0] count_next;
  logic [COUNTER_WIDTH-1:0] shadow_reg;
  logic                     ovf_reg;
  logic                     ovf_next;
  logic                     thr_reg;
  logic                     thr_next;
  logic                     ovf_set;
  logic                     thr_set;
  logic                     unused_wdata;

  assign unused_wdata = &{1'b0, wdata};
  assign armed        = (prime_reg == 3'(PRIME_CYCLES));
  assign hit          = armed & edge_hit(mode_reg, sample_reg, prev_reg);

  // Sample/previous pair for edge detection plus the post-reset priming count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_reg <= 1'b0;
      prev_reg   <= 1'b0;
      prime_reg  <= '0;
    end else begin
      sample_reg <= synced;
      prev_reg   <= sample_reg;
      if (!armed) begin
        prime_reg <= prime_reg + 3'd1;
      end
    end
  end

  // Next count and flag-set conditions; a clear in the same cycle swallows the event
  always_comb begin
    count_next = count_reg;
    ovf_set    = 1'b0;
    thr_set    = 1'b0;
    if (ctrl.clear) begin
      count_next = '0;
    end else if (hit) begin
      if (count_reg == COUNT_MAX) begin
        ovf_set    = 1'b1;
        count_next = sat_reg ? COUNT_MAX : '0;
      end else begin
        count_next = count_reg + 1'b1;
      end
      thr_set = (thresh_reg != '0) && (count_next == thresh_reg);
    end
  end

  // Sticky flags: software clear loses to a set arriving in the same cycle
  always_comb begin
    ovf_next = (ovf_reg & ~ctrl.ovf_clr) | ovf_set;
    thr_next = (thr_reg & ~ctrl.thr_clr) | thr_set;
  end

  // Counter, shadow, flags and configuration registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg  <= '0;
      shadow_reg <= '0;
      ovf_reg    <= 1'b0;
      thr_reg    <= 1'b0;
      mode_reg   <= EDGE_RISE;
      sat_reg    <= 1'b0;
      thresh_reg <= '0;
    end else begin
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      thr_reg   <= thr_next;
      if (ctrl.snapshot) begin
        shadow_reg <= count_reg;
      end
      if (ctrl.cfg_we) begin
        mode_reg <= edge_mode_t'(wdata[1:0]);
        sat_reg  <= wdata[2];
      end
      if (ctrl.thresh_we) begin
        thresh_reg <= wdata[COUNTER_WIDTH-1:0];
      end
    end
  end

  assign count    = count_reg;
  assign shadow   = shadow_reg;
  assign ovf_flag = ovf_reg;
  assign thr_flag = thr_reg;

endmodule

// File: rtl/multi_event_counter.sv
// Multi-channel event counter on the custom-instruction bus: CI decode,
// per-channel control strobes, read-back mux and the registered interrupt.
module multi_event_counter
  import multi_event_counter_pkg::*;
#(
  parameter logic [7:0] CUSTOM_INSTRUCTION_ID = 8'd0,
  parameter int         NUM_CHANNELS          = 4,
  parameter int         COUNTER_WIDTH         = 32,
  parameter int         SYNC_STAGES           = 2
) (
  input  logic                    systemClock,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] eventIn,
  output logic                    irq,
  input  logic                    ciStart,
  input  logic                    ciCke,
  input  logic [7:0]              ciN,
  input  logic [31:0]             ciValueA,
  input  logic [31:0]             ciValueB,
  output logic [31:0]             ciResult,
  output logic                    ciDone
);

  logic                     is_my_ci;
  logic                     ci_active;
  logic [3:0]               opcode;
  logic [3:0]               ch_idx;
  logic                     unused_a;
  logic [COUNTER_WIDTH-1:0] counts [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] shadows [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  ovf_flags;
  logic [NUM_CHANNELS-1:0]  thr_flags;
  logic [COUNTER_WIDTH-1:0] sel_count;
  logic [COUNTER_WIDTH-1:0] sel_shadow;
  logic [31:0]              status;
  logic [31:0]              result;
  logic                     irq_reg;

  // A CI arriving while reset is held is discarded and reports nothing
  assign is_my_ci  = ciStart & ciCke & (ciN == CUSTOM_INSTRUCTION_ID);
  assign ci_active = is_my_ci & reset;
  assign opcode    = ciValueA[3:0];
  assign ch_idx    = ciValueA[7:4];
  assign unused_a  = &{1'b0, ciValueA[31:8]};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic       ch_hit;
      chan_ctrl_t ctrl;

      // Channel indices outside the populated range never match, so writes to them vanish
      assign ch_hit = ci_active && (ch_idx == 4'(gi));

      // Turn the decoded CI into this channel's one-cycle control strobes
      always_comb begin
        ctrl           = '0;
        ctrl.clear     = (ch_hit && (opcode == OP_CLEAR_COUNT)) ||
                         (ci_active && (opcode == OP_CLEAR_ALL));
        ctrl.snapshot  = ci_active && (opcode == OP_SNAPSHOT);
        ctrl.cfg_we    = ch_hit && (opcode == OP_WRITE_CFG);
        ctrl.thresh_we = ch_hit && (opcode == OP_WRITE_THRESH);
        ctrl.ovf_clr   = ci_active && (opcode == OP_CLEAR_FLAGS) && ciValueB[STATUS_OVF_LSB + gi];
        ctrl.thr_clr   = ci_active && (opcode == OP_CLEAR_FLAGS) && ciValueB[STATUS_THR_LSB + gi];
      end

      event_counter_channel #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .SYNC_STAGES   (SYNC_STAGES)
      ) u_channel (
        .clk      (systemClock),
        .rst_n    (reset),
        .event_in (eventIn[gi]),
        .ctrl     (ctrl),
        .wdata    (ciValueB),
        .count    (counts[gi]),
        .shadow   (shadows[gi]),
        .ovf_flag (ovf_flags[gi]),
        .thr_flag (thr_flags[gi])
      );
    end
  endgenerate

  // Pick the addressed channel's live and shadow counts; unpopulated indices read 0
  always_comb begin
    sel_count  = '0;
    sel_shadow = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_idx == 4'(i)) begin
        sel_count  = counts[i];
        sel_shadow = shadows[i];
      end
    end
  end

  // Pack overflow and threshold flags into the status word
  always_comb begin
    status = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      status[STATUS_OVF_LSB + i] = ovf_flags[i];
      status[STATUS_THR_LSB + i] = thr_flags[i];
    end
  end

  // Result mux: only read opcodes return data, everything else returns 0
  always_comb begin
    result = '0;
    if (ci_active) begin
      case (opcode)
        OP_READ_COUNT:  result[COUNTER_WIDTH-1:0] = sel_count;
        OP_READ_SHADOW: result[COUNTER_WIDTH-1:0] = sel_shadow;
        OP_READ_STATUS: result = status;
        default:        result = '0;
      endcase
    end
  end

  // Interrupt is the registered OR of all threshold flags
  always_ff @(posedge systemClock) begin
    if (!reset) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= |thr_flags;
    end
  end

  assign irq      = irq_reg;
  assign ciResult = result;
  assign ciDone   = ci_active;

endmodule

// File: tb/tb_multi_event_counter.sv
// Directed self-checking bench for multi_event_counter (4 channels, 4-bit counters).
module tb_multi_event_counter;

  localparam logic [7:0] ID  = 8'h05;
  localparam int         NCH = 4;

  logic           systemClock;
  logic           reset;
  logic [NCH-1:0] eventIn;
  logic           irq;
  logic           ciStart;
  logic           ciCke;
  logic [7:0]     ciN;
  logic [31:0]    ciValueA;
  logic [31:0]    ciValueB;
  logic [31:0]    ciResult;
  logic           ciDone;

  int n_checks = 0;
  int n_errors = 0;

  multi_event_counter #(
    .CUSTOM_INSTRUCTION_ID (ID),
    .NUM_CHANNELS          (NCH),
    .COUNTER_WIDTH         (4),
    .SYNC_STAGES           (2)
  ) dut (
    .systemClock (systemClock),
    .reset       (reset),
    .eventIn     (eventIn),
    .irq         (irq),
    .ciStart     (ciStart),
    .ciCke       (ciCke),
    .ciN         (ciN),
    .ciValueA    (ciValueA),
    .ciValueB    (ciValueB),
    .ciResult    (ciResult),
    .ciDone      (ciDone)
  );

  initial systemClock = 1'b0;
  always #5 systemClock = ~systemClock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Combinational CI access: drive at a falling edge, sample, withdraw before the next rising edge
  task automatic ci_peek(input logic [7:0] n, input logic cke, input logic [3:0] op,
                         input logic [3:0] ch, input logic [31:0] b,
                         output logic [31:0] res, output logic done);
    @(negedge systemClock);
    ciStart  = 1'b1;
    ciCke    = cke;
    ciN      = n;
    ciValueA = {24'd0, ch, op};
    ciValueB = b;
    #1;
    res     = ciResult;
    done    = ciDone;
    ciStart = 1'b0;
    ciCke   = 1'b0;
    $display("peek  n=%02h op=%0d ch=%0d b=%08h -> result=%08h done=%0b", n, op, ch, b, res, done);
  endtask

  // Committing CI: held across one rising edge
  task automatic ci_write(input logic [7:0] n, input logic [3:0] op, input logic [3:0] ch,
                          input logic [31:0] b);
    @(negedge systemClock);
    ciStart  = 1'b1;
    ciCke    = 1'b1;
    ciN      = n;
    ciValueA = {24'd0, ch, op};
    ciValueB = b;
    @(posedge systemClock);
    #1;
    ciStart = 1'b0;
    ciCke   = 1'b0;
    $display("write n=%02h op=%0d ch=%0d b=%08h", n, op, ch, b);
  endtask

  task automatic read_val(input logic [3:0] op, input logic [3:0] ch, output logic [31:0] res);
    logic done;
    ci_peek(ID, 1'b1, op, ch, 32'd0, res, done);
  endtask

  // n one-cycle-high / one-cycle-low pulses, then let the pipeline drain
  task automatic pulses(input int ch, input int n);
    for (int p = 0; p < n; p++) begin
      @(negedge systemClock);
      eventIn[ch] = 1'b1;
      @(negedge systemClock);
      eventIn[ch] = 1'b0;
    end
    repeat (6) @(negedge systemClock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        d;

    reset    = 1'b0;
    eventIn  = '1;
    ciStart  = 1'b0;
    ciCke    = 1'b0;
    ciN      = 8'd0;
    ciValueA = 32'd0;
    ciValueB = 32'd0;
    repeat (4) @(negedge systemClock);

    // T1: CI during reset is discarded, then release with all inputs high
    ci_peek(ID, 1'b1, 4'd7, 4'd0, 32'd0, r, d);
    check("rst_ci_done", {31'd0, d}, 32'd0);
    check("rst_ci_result", r, 32'd0);
    @(negedge systemClock);
    reset = 1'b1;
    repeat (8) @(negedge systemClock);
    check("rst_irq", {31'd0, irq}, 32'd0);
    for (int c = 0; c < NCH; c++) begin
      read_val(4'd0, 4'(c), r);
      check($sformatf("rst_count%0d", c), r, 32'd0);
    end
    read_val(4'd7, 4'd0, r);
    check("rst_status", r, 32'd0);
    eventIn = '0;
    repeat (6) @(negedge systemClock);
    read_val(4'd0, 4'd0, r);
    check("prime_no_count", r, 32'd0);
    pulses(0, 3);
    read_val(4'd0, 4'd0, r);
    check("t1_count3", r, 32'd3);

    // T2: wrap on ch1, saturate on ch2
    pulses(1, 17);
    read_val(4'd0, 4'd1, r);
    check("wrap_count", r, 32'd1);
    read_val(4'd7, 4'd0, r);
    check("wrap_status", r, 32'h0000_0002);
    ci_write(ID, 4'd5, 4'd2, 32'h0000_0005);
    pulses(2, 20);
    read_val(4'd0, 4'd2, r);
    check("sat_count", r, 32'd15);
    read_val(4'd7, 4'd0, r);
    check("sat_status", r, 32'h0000_0006);
    ci_write(ID, 4'd8, 4'd0, 32'h0000_0006);
    read_val(4'd7, 4'd0, r);
    check("ovf_clear", r, 32'd0);

    // T3: threshold 5 on ch3, flag timing and irq lag
    ci_write(ID, 4'd6, 4'd3, 32'd5);
    pulses(3, 4);
    read_val(4'd7, 4'd0, r);
    check("thr_before", r, 32'd0);
    @(negedge systemClock);
    eventIn[3] = 1'b1;
    @(negedge systemClock);
    eventIn[3] = 1'b0;
    @(negedge systemClock);
    read_val(4'd7, 4'd0, r);
    check("thr_latency_early", r, 32'd0);
    read_val(4'd7, 4'd0, r);
    check("thr_flag", r, 32'h0008_0000);
    check("irq_lag0", {31'd0, irq}, 32'd0);
    @(negedge systemClock);
    check("irq_set", {31'd0, irq}, 32'd1);
    ci_write(ID, 4'd8, 4'd0, 32'h0008_0000);
    repeat (2) @(negedge systemClock);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    read_val(4'd0, 4'd3, r);
    check("thr_count", r, 32'd5);

    // T4: clear collides with an increment
    @(negedge systemClock);
    eventIn[0] = 1'b1;
    @(negedge systemClock);
    eventIn[0] = 1'b0;
    @(negedge systemClock);
    ci_write(ID, 4'd1, 4'd0, 32'd0);
    repeat (6) @(negedge systemClock);
    read_val(4'd0, 4'd0, r);
    check("clear_wins", r, 32'd0);
    pulses(0, 2);
    // Snapshot collides with an increment
    @(negedge systemClock);
    eventIn[0] = 1'b1;
    @(negedge systemClock);
    eventIn[0] = 1'b0;
    @(negedge systemClock);
    ci_write(ID, 4'd3, 4'd0, 32'd0);
    repeat (6) @(negedge systemClock);
    read_val(4'd4, 4'd0, r);
    check("snap_shadow", r, 32'd2);
    read_val(4'd0, 4'd0, r);
    check("snap_live", r, 32'd3);

    // T5: edge modes on ch1
    ci_write(ID, 4'd1, 4'd1, 32'd0);
    ci_write(ID, 4'd5, 4'd1, 32'h0000_0002);
    pulses(1, 4);
    read_val(4'd0, 4'd1, r);
    check("mode_fall", r, 32'd4);
    ci_write(ID, 4'd1, 4'd1, 32'd0);
    ci_write(ID, 4'd5, 4'd1, 32'h0000_0003);
    pulses(1, 4);
    read_val(4'd0, 4'd1, r);
    check("mode_both", r, 32'd8);
    ci_write(ID, 4'd5, 4'd1, 32'h0000_0000);
    read_val(4'd0, 4'd1, r);
    check("mode_off_keep", r, 32'd8);
    ci_write(ID, 4'd1, 4'd1, 32'd0);
    pulses(1, 4);
    read_val(4'd0, 4'd1, r);
    check("mode_off", r, 32'd0);

    // T6: decode
    ci_peek(ID + 8'd1, 1'b1, 4'd0, 4'd0, 32'd0, r, d);
    check("badn_done", {31'd0, d}, 32'd0);
    check("badn_result", r, 32'd0);
    ci_peek(ID, 1'b0, 4'd0, 4'd0, 32'd0, r, d);
    check("nocke_done", {31'd0, d}, 32'd0);
    ci_write(ID + 8'd1, 4'd2, 4'd0, 32'd0);
    read_val(4'd0, 4'd0, r);
    check("badn_no_clear", r, 32'd3);
    ci_peek(ID, 1'b1, 4'd0, 4'd15, 32'd0, r, d);
    check("ch15_done", {31'd0, d}, 32'd1);
    check("ch15_read", r, 32'd0);
    ci_write(ID, 4'd1, 4'd15, 32'd0);
    read_val(4'd0, 4'd0, r);
    check("ch15_no_clear", r, 32'd3);
    ci_peek(ID, 1'b1, 4'd9, 4'd0, 32'hFFFF_FFFF, r, d);
    check("noop_done", {31'd0, d}, 32'd1);
    check("noop_result", r, 32'd0);
    ci_peek(ID, 1'b1, 4'd1, 4'd0, 32'd0, r, d);
    check("write_result", r, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
